scope_capture_ctrl: RTL and testbench



---
 rtl/scope_capture_ctrl_if.sv | 15 +
 rtl/scope_capture_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_scope_capture_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scope_capture_ctrl_if.sv
// Sample-stream input and capture-RAM write port of the acquisition sequencer.
// The master side is the sequencer; the slave side is the ADC/RAM environment.
interface scope_capture_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 12
);
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (input sample_valid, sample_data, output wr_en, wr_addr, wr_data);
  modport slave  (output sample_valid, sample_data, input wr_en, wr_addr, wr_data);
endinterface

// File: rtl/scope_capture_ctrl.sv
// Acquisition sequencer: decimates one sample stream, fills a circular pretrigger
// window, waits for a level/edge trigger or force, then writes the posttrigger samples.
module scope_capture_ctrl #(
  parameter int AW = 10,
  parameter int DW = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  scope_capture_ctrl_if.master bus,
  input  logic                 arm,
  input  logic                 force_trig,
  input  logic [DW-1:0]        trig_level,
  input  logic                 trig_edge,
  input  logic [AW-1:0]        pretrig,
  input  logic [7:0]           decim,
  output logic [AW-1:0]        trig_addr,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        state_reg, state_next;
  logic [AW-1:0] ptr_reg, ptr_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic [7:0]    dcnt_reg, dcnt_next;
  logic          wr_en_reg, wr_en_next;
  logic [AW-1:0] wr_addr_reg, wr_addr_next;
  logic [DW-1:0] wr_data_reg, wr_data_next;
  logic [AW-1:0] trig_addr_reg, trig_addr_next;
  logic          prev_valid_reg, prev_valid_next;
  logic [DW-1:0] prev_reg, prev_next;
  logic          force_pend_reg, force_pend_next;
  logic [DW-1:0] level_reg, level_next;
  logic          edge_reg, edge_next;
  logic [AW-1:0] pretrig_reg, pretrig_next;
  logic [7:0]    decim_reg, decim_next;

  logic          accepted;
  logic          writing;
  logic          trig_hit;
  logic [AW-1:0] post_len;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      ptr_reg        <= '0;
      cnt_reg        <= '0;
      dcnt_reg       <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      trig_addr_reg  <= '0;
      prev_valid_reg <= 1'b0;
      prev_reg       <= '0;
      force_pend_reg <= 1'b0;
      level_reg      <= '0;
      edge_reg       <= 1'b0;
      pretrig_reg    <= '0;
      decim_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      cnt_reg        <= cnt_next;
      dcnt_reg       <= dcnt_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      trig_addr_reg  <= trig_addr_next;
      prev_valid_reg <= prev_valid_next;
      prev_reg       <= prev_next;
      force_pend_reg <= force_pend_next;
      level_reg      <= level_next;
      edge_reg       <= edge_next;
      pretrig_reg    <= pretrig_next;
      decim_reg      <= decim_next;
    end
  end

  // D-1-pretrig in AW bits; zero means the trigger sample completes the buffer.
  assign post_len = {AW{1'b1}} - pretrig_reg;
  assign accepted = bus.sample_valid && (dcnt_reg == decim_reg);
  assign writing  = (state_reg == S_PRE) || (state_reg == S_ARMED) || (state_reg == S_POST);

  always_comb begin
    trig_hit = force_pend_reg;
    if (prev_valid_reg) begin
      if (edge_reg)
        trig_hit = trig_hit || ((prev_reg > level_reg) && (bus.sample_data <= level_reg));
      else
        trig_hit = trig_hit || ((prev_reg < level_reg) && (bus.sample_data >= level_reg));
    end
  end

  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    cnt_next        = cnt_reg;
    dcnt_next       = dcnt_reg;
    wr_en_next      = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    trig_addr_next  = trig_addr_reg;
    prev_valid_next = prev_valid_reg;
    prev_next       = prev_reg;
    force_pend_next = force_pend_reg;
    level_next      = level_reg;
    edge_next       = edge_reg;
    pretrig_next    = pretrig_reg;
    decim_next      = decim_reg;

    if (bus.sample_valid)
      dcnt_next = accepted ? 8'd0 : dcnt_reg + 8'd1;

    if (force_trig && ((state_reg == S_PRE) || (state_reg == S_ARMED)))
      force_pend_next = 1'b1;

    if (accepted && writing) begin
      wr_en_next   = 1'b1;
      wr_addr_next = ptr_reg;
      wr_data_next = bus.sample_data;
      ptr_next     = ptr_reg + ONE;
      case (state_reg)
        S_PRE: begin
          prev_next       = bus.sample_data;
          prev_valid_next = 1'b1;
          if (cnt_reg + ONE == pretrig_reg) begin
            state_next = S_ARMED;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + ONE;
          end
        end
        S_ARMED: begin
          prev_next       = bus.sample_data;
          prev_valid_next = 1'b1;
          if (trig_hit) begin
            trig_addr_next  = ptr_reg;
            force_pend_next = 1'b0;
            cnt_next        = '0;
            state_next      = (post_len == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (cnt_reg + ONE == post_len)
            state_next = S_DONE;
          else
            cnt_next = cnt_reg + ONE;
        end
        default: ;
      endcase
    end

    // A force arriving together with arm belongs to the capture being started.
    if (arm) begin
      state_next      = (pretrig == '0) ? S_ARMED : S_PRE;
      ptr_next        = '0;
      cnt_next        = '0;
      dcnt_next       = 8'd0;
      wr_en_next      = 1'b0;
      wr_addr_next    = '0;
      wr_data_next    = wr_data_reg;
      prev_valid_next = 1'b0;
      force_pend_next = force_trig;
      level_next      = trig_level;
      edge_next       = trig_edge;
      pretrig_next    = pretrig;
      decim_next      = decim;
    end
  end

  assign bus.wr_en   = wr_en_reg;
  assign bus.wr_addr = wr_addr_reg;
  assign bus.wr_data = wr_data_reg;
  assign trig_addr   = trig_addr_reg;
  assign busy        = writing;
  assign done        = (state_reg == S_DONE);

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed bench for scope_capture_ctrl: a write-count based capture model is
// compared against the DUT every cycle, plus literal expectations per scenario.
module tb_scope_capture_ctrl;
  localparam int AW = 4;
  localparam int DW = 12;
  localparam int D  = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          arm, force_trig, trig_edge;
  logic [DW-1:0] trig_level;
  logic [AW-1:0] pretrig;
  logic [7:0]    decim;
  logic [AW-1:0] trig_addr;
  logic          busy, done;

  always #5 clock = ~clock;

  scope_capture_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  scope_capture_ctrl #(.AW(AW), .DW(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .arm        (arm),
    .force_trig (force_trig),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .pretrig    (pretrig),
    .decim      (decim),
    .trig_addr  (trig_addr),
    .busy       (busy),
    .done       (done)
  );

  int checks = 0;
  int errors = 0;
  int dut_writes = 0;
  bit check_en = 0;

  // Capture model: everything follows from how many samples this capture has written.
  int m_active, m_nw, m_trig_n, m_pre, m_dec, m_sc, m_fpend;
  int m_have_prev, m_prev, m_level, m_edge;
  int m_trig_addr, m_last_addr, m_last_data;
  int n_wr_en;
  int e_wr_en, e_addr, e_data, e_trig, e_busy, e_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cap_complete();
    return (m_trig_n >= 0) && (m_nw == m_trig_n + D - m_pre);
  endfunction

  task automatic model_step();
    int s;
    bit acc;
    bit crossed;
    n_wr_en = 0;
    if (reset) begin
      m_active = 0; m_sc = 0; m_dec = 0; m_fpend = 0; m_have_prev = 0;
      m_trig_addr = 0; m_last_addr = 0; m_last_data = 0; m_nw = 0; m_trig_n = -1;
    end else if (arm) begin
      m_active = 1; m_nw = 0; m_trig_n = -1;
      m_pre = int'(pretrig); m_dec = int'(decim); m_level = int'(trig_level);
      m_edge = int'(trig_edge); m_sc = 0; m_fpend = int'(force_trig);
      m_have_prev = 0; m_last_addr = 0;
    end else begin
      acc = 0;
      s = int'(bus.sample_data);
      if (bus.sample_valid) begin
        acc = ((m_sc % (m_dec + 1)) == m_dec);
        m_sc++;
      end
      if (acc && m_active != 0 && cap_complete() == 0) begin
        n_wr_en = 1;
        m_last_addr = m_nw % D;
        m_last_data = s;
        if (m_edge != 0) crossed = (m_prev > m_level) && (s <= m_level);
        else             crossed = (m_prev < m_level) && (s >= m_level);
        if (m_trig_n < 0 && m_nw >= m_pre && (m_fpend != 0 || (m_have_prev != 0 && crossed))) begin
          m_trig_n = m_nw;
          m_trig_addr = m_nw % D;
        end
        if (m_trig_n < 0) begin
          m_have_prev = 1;
          m_prev = s;
        end
        m_nw++;
      end
      if (force_trig && m_active != 0 && m_trig_n < 0) m_fpend = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    e_wr_en = n_wr_en;
    e_addr  = m_last_addr;
    e_data  = m_last_data;
    e_trig  = m_trig_addr;
    e_busy  = (m_active != 0) && (cap_complete() == 0);
    e_done  = (m_active != 0) && (cap_complete() != 0);
    arm = 1'b0; force_trig = 1'b0; bus.sample_valid = 1'b0; reset = 1'b0;
  endtask

  task automatic send(input int s);
    bus.sample_valid = 1'b1;
    bus.sample_data  = DW'(s);
    tick();
    tick();
  endtask

  task automatic do_arm(input int pre, input int dec, input int lvl, input int edg, input int frc);
    pretrig = AW'(pre); decim = 8'(dec); trig_level = DW'(lvl);
    trig_edge = edg[0]; force_trig = frc[0]; arm = 1'b1;
    tick();
    // Disturb the live inputs; the capture must keep the values seen at arm.
    pretrig = ~pretrig; trig_level = ~trig_level; decim = 8'd0; trig_edge = ~trig_edge;
    dut_writes = 0;
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      if (bus.wr_en === 1'b1) dut_writes++;
      chk("wr_en", 32'(bus.wr_en), 32'(e_wr_en));
      chk("wr_addr", 32'(bus.wr_addr), 32'(e_addr));
      chk("wr_data", 32'(bus.wr_data), 32'(e_data));
      chk("trig_addr", 32'(trig_addr), 32'(e_trig));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
    end
  end

  initial begin
    reset = 1'b1; arm = 1'b0; force_trig = 1'b0; trig_edge = 1'b0;
    trig_level = '0; pretrig = '0; decim = '0;
    bus.sample_valid = 1'b0; bus.sample_data = '0;
    tick();
    check_en = 1;
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    send(12'h555);
    chk("idle_no_write", 32'(dut_writes), 32'h0);

    // Rising edge, pretrig 4: crossing happens on the fifth sample (0x800).
    do_arm(4, 0, 12'h800, 0, 0);
    for (int k = 0; k < 16; k++) send(12'h600 + k * 12'h080);
    chk("rise_trig_addr", 32'(trig_addr), 32'd4);
    chk("rise_writes", 32'(dut_writes), 32'd16);
    chk("rise_model_nw", 32'(m_nw), 32'd16);
    chk("rise_done", 32'(done), 32'd1);
    chk("rise_last_data", 32'(bus.wr_data), 32'hD80);
    send(12'h111);
    chk("rise_no_write_done", 32'(dut_writes), 32'd16);

    // Falling edge; equal-to-level counts.
    do_arm(1, 0, 12'h400, 1, 0);
    send(12'h500); send(12'h450); send(12'h400);
    chk("fall_trig_addr", 32'(trig_addr), 32'd2);
    for (int k = 0; k < 14; k++) send(12'h400);
    chk("fall_writes", 32'(dut_writes), 32'd17);
    chk("fall_done", 32'(done), 32'd1);

    // A flat level must not trigger; only a real crossing does.
    do_arm(1, 0, 12'h400, 1, 0);
    for (int k = 0; k < 6; k++) send(12'h400);
    chk("flat_done", 32'(done), 32'd0);
    chk("flat_busy", 32'(busy), 32'd1);
    chk("flat_trig_held", 32'(trig_addr), 32'd2);
    send(12'h450); send(12'h400);
    chk("flat_trig_addr", 32'(trig_addr), 32'd7);
    for (int k = 0; k < 14; k++) send(12'h400);
    chk("flat_writes", 32'(dut_writes), 32'd22);

    // Decimation by 3: strobes 3,6,...,30 written.
    do_arm(4, 2, 12'hFFF, 0, 0);
    for (int k = 1; k <= 30; k++) send(k * 12'h010);
    chk("dec_writes", 32'(dut_writes), 32'd10);
    chk("dec_last_data", 32'(bus.wr_data), 32'h1E0);
    chk("dec_last_addr", 32'(bus.wr_addr), 32'd9);

    // pretrig 0 with force at arm: first sample is the trigger.
    do_arm(0, 0, 12'h800, 0, 1);
    for (int k = 0; k < 16; k++) send(12'h123 + k);
    chk("f0_trig_addr", 32'(trig_addr), 32'd0);
    chk("f0_writes", 32'(dut_writes), 32'd16);
    chk("f0_done", 32'(done), 32'd1);

    // pretrig 15: ARMED wraps, trigger completes the buffer with no post writes.
    do_arm(15, 0, 12'h800, 0, 0);
    for (int k = 0; k < 18; k++) send(12'h100);
    send(12'h900);
    chk("p15_trig_addr", 32'(trig_addr), 32'd2);
    chk("p15_done", 32'(done), 32'd1);
    send(12'h100); send(12'h900);
    chk("p15_writes", 32'(dut_writes), 32'd19);

    // Force during PRE waits for the full pretrigger window.
    do_arm(8, 0, 12'h800, 0, 0);
    send(12'h100); send(12'h100);
    force_trig = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) send(12'h100);
    chk("fpre_no_trig_yet", 32'(trig_addr), 32'd2);
    chk("fpre_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 8; k++) send(12'h100);
    chk("fpre_trig_addr", 32'(trig_addr), 32'd8);
    chk("fpre_done", 32'(done), 32'd1);
    chk("fpre_writes", 32'(dut_writes), 32'd16);

    // Abort mid-POST with arm coinciding with an accepted sample.
    do_arm(4, 0, 12'h800, 0, 0);
    for (int k = 0; k < 8; k++) send(12'h600 + k * 12'h080);
    bus.sample_valid = 1'b1;
    bus.sample_data  = 12'hABC;
    do_arm(4, 0, 12'h800, 0, 0);
    chk("abort_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("abort_wr_en", 32'(bus.wr_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_trig_held", 32'(trig_addr), 32'd4);

    // Reset while ARMED clears everything and blocks writes.
    for (int k = 0; k < 5; k++) send(12'h100);
    reset = 1'b1;
    tick();
    chk("rst2_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst2_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst2_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst2_trig_addr", 32'(trig_addr), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_done", 32'(done), 32'd0);
    dut_writes = 0;
    for (int k = 0; k < 5; k++) send(12'h900);
    chk("rst2_no_writes", 32'(dut_writes), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
